pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Central sequencer for the IF/ID, ID/EX and EX/MEM pipeline registers and the PC.
//  Decides stall, flush and hlt each cycle from the following hazard sources:
//   - load-use hazard
//   - taken branch resolved in EX
//   - instruction-fetch wait
//   - data-memory busy
//   - HLT instruction decoded in ID
//  Sequences the halt drain and maintains a saturating bubble counter.
// PARAMETERS
//  REG_W         5   register-specifier width
//  DRAIN_CYCLES  3   cycles from halt-in-ID to freeze (EX, MEM, WB retire)
//  CNT_W         16  bubble-counter width
// PORTS
//  clk            in   1      clock; all state updates on posedge
//  rst            in   1      synchronous, active-high reset
//  ID_rs1         in   REG_W  source reg 1 of instruction in ID
//  ID_rs2         in   REG_W  source reg 2 of instruction in ID
//  ID_use_rs1     in   1      ID instruction reads rs1
//  ID_use_rs2     in   1      ID instruction reads rs2
//  ID_hlt         in   1      ID holds a HLT instruction
//  EX_is_load     in   1      EX holds a load
//  EX_rd          in   REG_W  EX destination reg
//  EX_br_taken    in   1      branch/jump resolved taken in EX
//  imem_ready     in   1      fetch data valid this cycle
//  dmem_busy      in   1      data memory not done; whole pipe must hold
//  pc_stall       out  1      PC holds
//  IF_ID_stall    out  1      IF/ID holds
//  IF_ID_flush    out  1      IF/ID loads bubble
//  ID_EX_stall    out  1      ID/EX holds
//  ID_EX_flush    out  1      ID/EX loads bubble
//  EX_MEM_stall   out  1      EX/MEM holds
//  hlt            out  1      global freeze to all pipeline regs
//  halted         out  1      processor halted (status)
//  bubble_cnt     out  CNT_W  cycles lost to stalls/bubbles, saturating
// BEHAVIOUR
//  State register: RUN, DRAIN, HALTED (registered). Control outputs are combinational from state and inputs.
//  rst=1: state<=RUN, drain_cnt<=0, bubble_cnt<=0. While rst=1, all outputs are forced 0.
//   Reset mid-DRAIN or in HALTED returns to RUN on the next edge.
//  RUN: highest-priority condition wins; exactly one applies per cycle.
//   1. dmem_busy: pc_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall = 1; all flushes 0.
//   2. EX_br_taken: IF_ID_flush=1, ID_EX_flush=1; no stall.
//      A HLT in ID is squashed by this; state stays RUN.
//   3. load-use: EX_is_load & EX_rd!=0 & ((ID_use_rs1 & ID_rs1==EX_rd) | (ID_use_rs2 & ID_rs2==EX_rd)).
//      Response: pc_stall=1, IF_ID_stall=1, ID_EX_flush=1. Exactly 1 bubble per hazard.
//   4. ID_hlt: pc_stall=1, IF_ID_flush=1; HLT advances to EX.
//      Next state DRAIN; drain_cnt<=DRAIN_CYCLES-1.
//   5. !imem_ready: pc_stall=1, IF_ID_flush=1 (bubble into ID).
//   6. otherwise all outputs 0.
//  DRAIN: pc_stall=1, IF_ID_flush=1 every cycle.
//   dmem_busy also asserts the rule-1 stalls and freezes drain_cnt.
//   When !dmem_busy: drain_cnt==0 -> HALTED, else drain_cnt decrements.
//   Branch, load-use, ID_hlt and imem_ready are ignored.
//  HALTED: hlt=1, pc_stall=1, halted=1; all other control outputs 0. Exit only by rst.
//  bubble_cnt: +1 on each cycle in RUN or DRAIN with pc_stall=1, or with (IF_ID_flush | ID_EX_flush)=1.
//   Holds at 2^CNT_W-1; does not count in HALTED.
//  Comparisons use the full REG_W bits; register 0 never causes a load-use hazard.
// TESTING
//  T1: EX_is_load=1, EX_rd=5, ID_rs1=5, ID_use_rs1=1 for 1 cycle
//      -> pc_stall/IF_ID_stall/ID_EX_flush=1 that cycle; bubble_cnt=1.
//  T2: same as T1 but EX_rd=0 -> no stall; bubble_cnt stays 0.
//  T3: EX_br_taken=1, ID_hlt=1, EX load-use all true
//      -> IF_ID_flush=ID_EX_flush=1, stalls 0; state stays RUN.
//  T4: ID_hlt=1, then dmem_busy=1 on the 2nd DRAIN cycle for 2 cycles
//      -> HALTED on cycle 1+DRAIN_CYCLES+2; hlt=halted=1 thereafter.
//  T5: in HALTED, assert rst 1 cycle -> next cycle all outputs 0, state RUN, bubble_cnt=0.
//  T6: CNT_W=4, imem_ready=0 for 20 cycles -> bubble_cnt reaches 15 and holds.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard sources in, pipeline-register control out. The controller uses the slave
// modport; the pipeline, or a bench standing in for it, uses the master modport.
interface pipeline_hazard_ctrl_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  logic [REG_W-1:0] ID_rs1;
  logic [REG_W-1:0] ID_rs2;
  logic             ID_use_rs1;
  logic             ID_use_rs2;
  logic             ID_hlt;
  logic             EX_is_load;
  logic [REG_W-1:0] EX_rd;
  logic             EX_br_taken;
  logic             imem_ready;
  logic             dmem_busy;
  logic             pc_stall;
  logic             IF_ID_stall;
  logic             IF_ID_flush;
  logic             ID_EX_stall;
  logic             ID_EX_flush;
  logic             EX_MEM_stall;
  logic             hlt;
  logic             halted;
  logic [CNT_W-1:0] bubble_cnt;

  modport master (
    output ID_rs1, ID_rs2, ID_use_rs1, ID_use_rs2, ID_hlt,
    output EX_is_load, EX_rd, EX_br_taken, imem_ready, dmem_busy,
    input  pc_stall, IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush,
    input  EX_MEM_stall, hlt, halted, bubble_cnt
  );

  modport slave (
    input  ID_rs1, ID_rs2, ID_use_rs1, ID_use_rs2, ID_hlt,
    input  EX_is_load, EX_rd, EX_br_taken, imem_ready, dmem_busy,
    output pc_stall, IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush,
    output EX_MEM_stall, hlt, halted, bubble_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/halt sequencer for the PC and the IF/ID, ID/EX and EX/MEM registers,
// with a halt-drain FSM and a saturating count of cycles lost to bubbles.
module pipeline_hazard_ctrl #(
  parameter int REG_W        = 5,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  pipeline_hazard_ctrl_if.slave hif,
  output logic [1:0]            dbg_state
);
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0]    DRAIN_INIT = DW'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_DRAIN  = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [DW-1:0]    drain_cnt_q, drain_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  logic load_use;
  logic pc_stall_c, if_id_stall_c, if_id_flush_c, id_ex_stall_c;
  logic id_ex_flush_c, ex_mem_stall_c, hlt_c, halted_c;

  // Register 0 is hard-wired, so a load targeting it can never create a hazard.
  assign load_use = hif.EX_is_load && (hif.EX_rd != '0) &&
                    ((hif.ID_use_rs1 && (hif.ID_rs1 == hif.EX_rd)) ||
                     (hif.ID_use_rs2 && (hif.ID_rs2 == hif.EX_rd)));

  always_comb begin
    pc_stall_c     = 1'b0;
    if_id_stall_c  = 1'b0;
    if_id_flush_c  = 1'b0;
    id_ex_stall_c  = 1'b0;
    id_ex_flush_c  = 1'b0;
    ex_mem_stall_c = 1'b0;
    hlt_c          = 1'b0;
    halted_c       = 1'b0;
    state_d        = state_q;
    drain_cnt_d    = drain_cnt_q;

    case (state_q)
      S_RUN: begin
        if (hif.dmem_busy) begin
          pc_stall_c     = 1'b1;
          if_id_stall_c  = 1'b1;
          id_ex_stall_c  = 1'b1;
          ex_mem_stall_c = 1'b1;
        end else if (hif.EX_br_taken) begin
          if_id_flush_c = 1'b1;
          id_ex_flush_c = 1'b1;
        end else if (load_use) begin
          pc_stall_c    = 1'b1;
          if_id_stall_c = 1'b1;
          id_ex_flush_c = 1'b1;
        end else if (hif.ID_hlt) begin
          pc_stall_c    = 1'b1;
          if_id_flush_c = 1'b1;
          state_d       = S_DRAIN;
          drain_cnt_d   = DRAIN_INIT;
        end else if (!hif.imem_ready) begin
          pc_stall_c    = 1'b1;
          if_id_flush_c = 1'b1;
        end
      end
      S_DRAIN: begin
        // Older instructions retire behind the HLT; nothing new may enter.
        pc_stall_c    = 1'b1;
        if_id_flush_c = 1'b1;
        if (hif.dmem_busy) begin
          if_id_stall_c  = 1'b1;
          id_ex_stall_c  = 1'b1;
          ex_mem_stall_c = 1'b1;
        end else if (drain_cnt_q == '0) begin
          state_d = S_HALTED;
        end else begin
          drain_cnt_d = drain_cnt_q - DW'(1);
        end
      end
      S_HALTED: begin
        hlt_c      = 1'b1;
        pc_stall_c = 1'b1;
        halted_c   = 1'b1;
      end
      default: begin
        state_d = S_RUN;
      end
    endcase

    bubble_cnt_d = bubble_cnt_q;
    if ((state_q != S_HALTED) && (pc_stall_c || if_id_flush_c || id_ex_flush_c) &&
        (bubble_cnt_q != CNT_MAX)) begin
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_RUN;
      drain_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      drain_cnt_q  <= drain_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  // Reset masks every output, including the counter and the debug state.
  assign hif.pc_stall     = pc_stall_c     && !rst;
  assign hif.IF_ID_stall  = if_id_stall_c  && !rst;
  assign hif.IF_ID_flush  = if_id_flush_c  && !rst;
  assign hif.ID_EX_stall  = id_ex_stall_c  && !rst;
  assign hif.ID_EX_flush  = id_ex_flush_c  && !rst;
  assign hif.EX_MEM_stall = ex_mem_stall_c && !rst;
  assign hif.hlt          = hlt_c          && !rst;
  assign hif.halted       = halted_c       && !rst;
  assign hif.bubble_cnt   = rst ? '0 : bubble_cnt_q;
  assign dbg_state        = rst ? S_RUN : state_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: vector table for single-cycle priority decisions,
// hand sequences for drain, reset and counter saturation.
module tb_pipeline_hazard_ctrl;
  localparam int W = 26;

  logic clk = 1'b0;
  logic rst;
  logic [1:0] dbg_a, dbg_b;

  pipeline_hazard_ctrl_if #(.REG_W(5), .CNT_W(16)) ifa ();
  pipeline_hazard_ctrl_if #(.REG_W(5), .CNT_W(4))  ifb ();

  pipeline_hazard_ctrl #(.REG_W(5), .DRAIN_CYCLES(3), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .hif(ifa), .dbg_state(dbg_a));
  pipeline_hazard_ctrl #(.REG_W(5), .DRAIN_CYCLES(3), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .hif(ifb), .dbg_state(dbg_b));

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic       busy;
    logic       br;
    logic       ld;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic       hl;
    logic       rdy;
  } vin_t;

  typedef struct {
    vin_t       v;
    logic [7:0] ctrl;
    string      name;
  } vec_t;

  // ctrl bits: {pc_stall, IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush, EX_MEM_stall, hlt, halted}
  localparam logic [7:0] C_NONE  = 8'b0000_0000;
  localparam logic [7:0] C_LDU   = 8'b1100_1000;
  localparam logic [7:0] C_BR    = 8'b0010_1000;
  localparam logic [7:0] C_MEM   = 8'b1101_0100;
  localparam logic [7:0] C_FETCH = 8'b1010_0000;
  localparam logic [7:0] C_DRB   = 8'b1111_0100;
  localparam logic [7:0] C_HALT  = 8'b1000_0011;

  logic [W-1:0] exp_q[$];
  logic [3:0]   exp4_q[$];
  logic [15:0]  exp_bub;
  int checks = 0;
  int errors = 0;
  vec_t tbl[13];

  function automatic vin_t mkv(logic busy, logic br, logic ld, logic [4:0] rd,
                               logic [4:0] rs1, logic [4:0] rs2, logic u1, logic u2,
                               logic hl, logic rdy);
    vin_t v;
    v.rst = 1'b0; v.busy = busy; v.br = br; v.ld = ld; v.rd = rd;
    v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.hl = hl; v.rdy = rdy;
    return v;
  endfunction

  function automatic vin_t idle();
    return mkv(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
  endfunction

  function automatic vin_t noise(logic busy);
    return mkv(busy, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
               5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)));
  endfunction

  task automatic drive(input vin_t v);
    rst             = v.rst;
    ifa.dmem_busy   = v.busy;
    ifa.EX_br_taken = v.br;
    ifa.EX_is_load  = v.ld;
    ifa.EX_rd       = v.rd;
    ifa.ID_rs1      = v.rs1;
    ifa.ID_rs2      = v.rs2;
    ifa.ID_use_rs1  = v.u1;
    ifa.ID_use_rs2  = v.u2;
    ifa.ID_hlt      = v.hl;
    ifa.imem_ready  = v.rdy;
  endtask

  // One clock of dut_a: drive, push expectation, compare at negedge, update model.
  task automatic apply(input vin_t v, input logic [7:0] ec, input logic [1:0] es,
                       input string name);
    logic [W-1:0] e, a;
    drive(v);
    exp_q.push_back({ec, es, (v.rst ? 16'd0 : exp_bub)});
    @(negedge clk);
    e = exp_q.pop_front();
    a = {ifa.pc_stall, ifa.IF_ID_stall, ifa.IF_ID_flush, ifa.ID_EX_stall,
         ifa.ID_EX_flush, ifa.EX_MEM_stall, ifa.hlt, ifa.halted, dbg_a, ifa.bubble_cnt};
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: ctrl=%b state=%0d bubble=%0d, expected ctrl=%b state=%0d bubble=%0d",
               name, a[25:18], a[17:16], a[15:0], e[25:18], e[17:16], e[15:0]);
    end
    if (v.rst) exp_bub = 16'd0;
    else if ((es != 2'd2) && (ec[7] || ec[5] || ec[3]) && (exp_bub != 16'hFFFF))
      exp_bub = exp_bub + 16'd1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_bub = 16'd0;
    ifb.dmem_busy = 1'b0; ifb.EX_br_taken = 1'b0; ifb.EX_is_load = 1'b0;
    ifb.EX_rd = '0; ifb.ID_rs1 = '0; ifb.ID_rs2 = '0; ifb.ID_use_rs1 = 1'b0;
    ifb.ID_use_rs2 = 1'b0; ifb.ID_hlt = 1'b0; ifb.imem_ready = 1'b1;

    tbl[0]  = '{idle(), C_NONE, "idle"};
    tbl[1]  = '{mkv(0,0,1,5'd5,5'd5,5'd0,1,0,0,1), C_LDU, "t1_load_use_rs1"};
    tbl[2]  = '{mkv(0,0,1,5'd0,5'd0,5'd0,1,1,0,1), C_NONE, "t2_rd_zero"};
    tbl[3]  = '{mkv(0,0,1,5'd7,5'd3,5'd7,1,1,0,1), C_LDU, "load_use_rs2"};
    tbl[4]  = '{mkv(0,0,1,5'd7,5'd3,5'd7,1,0,0,1), C_NONE, "rs2_unused"};
    tbl[5]  = '{mkv(0,0,1,5'h11,5'h01,5'h01,1,1,0,1), C_NONE, "full_width_cmp"};
    tbl[6]  = '{mkv(0,0,0,5'd9,5'd9,5'd9,1,1,0,1), C_NONE, "not_load"};
    tbl[7]  = '{mkv(0,0,0,5'd0,5'd0,5'd0,0,0,0,0), C_FETCH, "fetch_wait"};
    tbl[8]  = '{mkv(0,1,1,5'd4,5'd4,5'd0,1,0,1,0), C_BR, "t3_branch_wins"};
    tbl[9]  = '{mkv(1,1,1,5'd4,5'd4,5'd0,1,0,1,0), C_MEM, "dmem_over_all"};
    tbl[10] = '{mkv(1,0,0,5'd0,5'd0,5'd0,0,0,0,1), C_MEM, "dmem_alone"};
    tbl[11] = '{mkv(0,0,1,5'd31,5'd2,5'd31,0,1,0,0), C_LDU, "ldu_over_fetch"};
    tbl[12] = '{mkv(0,1,0,5'd0,5'd0,5'd0,0,0,0,1), C_BR, "branch_alone"};

    begin
      vin_t r;
      r = idle();
      r.rst = 1'b1;
      apply(r, C_NONE, 2'd0, "reset_hold");
      apply(r, C_NONE, 2'd0, "reset_hold2");
    end
    apply(idle(), C_NONE, 2'd0, "post_reset");

    for (int i = 0; i < 13; i++) apply(tbl[i].v, tbl[i].ctrl, 2'd0, tbl[i].name);

    // Reset in the middle of a drain returns straight to RUN.
    apply(mkv(0,0,0,5'd0,5'd0,5'd0,0,0,1,1), C_FETCH, 2'd0, "rd_hlt");
    apply(noise(1'b0), C_FETCH, 2'd1, "rd_drain");
    begin
      vin_t r;
      r = idle();
      r.rst = 1'b1;
      apply(r, C_NONE, 2'd0, "rd_reset");
    end
    apply(idle(), C_NONE, 2'd0, "rd_run");

    // T4: HLT, drain with dmem_busy on 2nd and 3rd drain cycles, then HALTED.
    apply(mkv(0,0,0,5'd0,5'd0,5'd0,0,0,1,1), C_FETCH, 2'd0, "t4_hlt");
    apply(noise(1'b0), C_FETCH, 2'd1, "t4_drain1");
    apply(noise(1'b1), C_DRB,   2'd1, "t4_drain_busy1");
    apply(noise(1'b1), C_DRB,   2'd1, "t4_drain_busy2");
    apply(noise(1'b0), C_FETCH, 2'd1, "t4_drain3");
    apply(noise(1'b0), C_FETCH, 2'd1, "t4_drain4");
    for (int i = 0; i < 4; i++) apply(noise(1'($urandom_range(0, 1))), C_HALT, 2'd2, "t4_halted");

    // T5: reset out of HALTED.
    begin
      vin_t r;
      r = noise(1'b0);
      r.rst = 1'b1;
      apply(r, C_NONE, 2'd0, "t5_reset");
    end
    apply(idle(), C_NONE, 2'd0, "t5_run");
    apply(idle(), C_NONE, 2'd0, "t5_run2");

    // T6: 4-bit counter saturates under a long fetch wait.
    begin
      logic [3:0] m4, e4;
      m4 = 4'd0;
      ifb.imem_ready = 1'b0;
      for (int i = 0; i < 21; i++) begin
        exp4_q.push_back(m4);
        @(negedge clk);
        e4 = exp4_q.pop_front();
        checks++;
        if ((ifb.bubble_cnt !== e4) || (ifb.pc_stall !== 1'b1)) begin
          errors++;
          $display("FAIL t6_saturate[%0d]: bubble=%0d pc_stall=%b, expected bubble=%0d pc_stall=1",
                   i, ifb.bubble_cnt, ifb.pc_stall, e4);
        end
        if (m4 != 4'd15) m4 = m4 + 4'd1;
        @(posedge clk);
        #1;
      end
      ifb.imem_ready = 1'b1;
    end

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
